baud_gen: RTL

Programmable UART timing generator. It produces an oversample tick, a mid-bit sample tick and a bit-boundary tick from the system clock. The divisor is runtime-loadable and its load is glitch-free. Sits between the register/config interface and the UART TX/RX state machines; RX uses i_srst to re-phase on start-bit detection.

---
 rtl/baud_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/baud_gen.sv
// UART timing generator: oversample, mid-bit and bit-boundary ticks with a glitch-free runtime divisor load.
// Optional BAUD_FRAC_EN adds a 1/16-cycle fractional divisor via i_frac.
module baud_gen #(
  parameter int CNT_W   = 16,
  parameter int OVS     = 16,
  parameter int OVS_W   = 4,
  parameter int DIV_RST = 27
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_srst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_ld,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]       i_frac,
`endif
  output logic             o_ovs_tick,
  output logic             o_mid_tick,
  output logic             o_bit_tick,
  output logic [CNT_W-1:0] o_div,
  output logic             o_div_err
);

  localparam logic [OVS_W-1:0] PH_MID  = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] PH_LAST = OVS_W'(OVS - 1);

  logic [CNT_W-1:0] r_pre_cnt;
  logic [OVS_W-1:0] r_ph_cnt;
  logic [CNT_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_div_sh;
  logic             r_ld_pend;
  logic             r_ovs_tick;
  logic             r_mid_tick;
  logic             r_bit_tick;
  logic             r_div_err;

  logic [CNT_W-1:0] w_period_m1;
  logic             w_wrap;
  logic             w_xfer;
  logic             w_ld_ok;

`ifdef BAUD_FRAC_EN
  logic [3:0] r_frac_acc;
  logic       r_extra;
  logic [4:0] w_acc_sum;

  always_comb begin
    w_acc_sum = {1'b0, r_frac_acc} + {1'b0, i_frac};
  end

  // A carry out of the accumulator stretches the following period by one clock.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_frac_acc <= '0;
      r_extra    <= 1'b0;
    end else if (i_srst) begin
      r_frac_acc <= '0;
      r_extra    <= 1'b0;
    end else if (w_wrap) begin
      r_frac_acc <= w_acc_sum[3:0];
      r_extra    <= w_acc_sum[4];
    end
  end

  always_comb begin
    w_period_m1 = r_div_q - CNT_W'(1) + CNT_W'(r_extra);
  end
`else
  always_comb begin
    w_period_m1 = r_div_q - CNT_W'(1);
  end
`endif

  // >= rather than == so a divisor shrunk while disabled cannot strand the count.
  always_comb begin
    w_wrap  = i_en && !i_srst && (r_pre_cnt >= w_period_m1);
    w_xfer  = r_ld_pend && (i_srst || w_wrap || !i_en);
    w_ld_ok = i_div_ld && (i_div != '0);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_pre_cnt <= '0;
      r_ph_cnt  <= '0;
    end else if (i_srst) begin
      r_pre_cnt <= '0;
      r_ph_cnt  <= '0;
    end else if (w_wrap) begin
      r_pre_cnt <= '0;
      r_ph_cnt  <= (r_ph_cnt == PH_LAST) ? '0 : r_ph_cnt + OVS_W'(1);
    end else if (i_en) begin
      r_pre_cnt <= r_pre_cnt + CNT_W'(1);
    end
  end

  // The shadow captured this cycle is only seen by a later transfer.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_div_q   <= CNT_W'(DIV_RST);
      r_div_sh  <= CNT_W'(DIV_RST);
      r_ld_pend <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_div_q <= r_div_sh;
      end
      if (w_ld_ok) begin
        r_div_sh  <= i_div;
        r_ld_pend <= 1'b1;
      end else if (w_xfer) begin
        r_ld_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_ovs_tick <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      r_ovs_tick <= w_wrap;
      r_mid_tick <= w_wrap && (r_ph_cnt == PH_MID);
      r_bit_tick <= w_wrap && (r_ph_cnt == PH_LAST);
      r_div_err  <= i_div_ld && (i_div == '0);
    end
  end

  assign o_ovs_tick = r_ovs_tick;
  assign o_mid_tick = r_mid_tick;
  assign o_bit_tick = r_bit_tick;
  assign o_div      = r_div_q;
  assign o_div_err  = r_div_err;

endmodule
